fir_mac_seq: RTL and testbench
==============================

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed sample width.
REQ-002 SHALL have parameter COEF_W, default 8: signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 3: tap count, legal range 2..16.
REQ-004 SHALL have parameter DOUT_W, default 15: output width; ACC_W = DATA_W+COEF_W+clog2(TAPS) is the internal accumulator width.
REQ-005 SHALL have one clock and synchronous active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-006 data_in, input, DATA_W, signed sample.
REQ-007 valid_in, input, 1, sample offered.
REQ-008 ready_out, output, 1, block can accept a sample.
REQ-009 coef_wr, input, 1, coefficient write strobe.
REQ-010 coef_addr, input, clog2(TAPS), coefficient index.
REQ-011 coef_data, input, COEF_W, signed coefficient.
REQ-012 data_out, output, DOUT_W, signed filter result.
REQ-013 valid_out, output, 1, one-cycle pulse marking data_out new.

Function
REQ-014 SHALL compute y = sum over k of x[k]*h[k], with x[0] the newest accepted sample, using one shared signed multiplier.
REQ-015 FSM SHALL have states IDLE, MAC, and DONE.
- IDLE -> MAC on valid_in&&ready_out.
- MAC -> DONE after tap TAPS-1.
- DONE -> IDLE unconditionally.
REQ-016 ready_out SHALL be 1 only in IDLE; valid_in outside IDLE is ignored and the sample is not consumed.
REQ-017 On accept, the delay line SHALL shift (x[k] <= x[k-1], x[0] <= data_in), accumulator cleared, tap index set to 0.
REQ-018 In MAC, each cycle SHALL add sign-extended full-precision x[idx]*h[idx] to the accumulator and increment idx; MAC lasts exactly TAPS cycles.
REQ-019 Accumulator SHALL be ACC_W bits and never overflow internally.
REQ-020 In DONE, data_out SHALL be updated and valid_out SHALL be 1 for exactly that cycle; data_out holds its value until the next DONE.
REQ-021 Latency: sample accepted at edge T SHALL produce valid_out in cycle T+TAPS+1; maximum throughput is one sample per TAPS+2 cycles.
REQ-022 coef_wr SHALL write h[coef_addr] only in IDLE.
- coef_wr in MAC/DONE is ignored.
- coef_addr >= TAPS is ignored.
REQ-023 coef_wr and sample accept in the same IDLE cycle SHALL both take effect; the new coefficient is used by that computation.

Reset
REQ-024 rst SHALL force state IDLE, ready_out=1, valid_out=0, data_out=0, accumulator=0, idx=0, all x[k]=0, all h[k]=0.
REQ-025 rst during MAC or DONE SHALL abort the computation with no valid_out pulse; the first sample after reset sees a zeroed delay line.

Configuration
REQ-026 Macro FIR_SAT_EN defined: data_out SHALL be the accumulator saturated to the signed DOUT_W range [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
REQ-027 FIR_SAT_EN undefined: data_out SHALL be accumulator bits [DOUT_W-1:0] (two's-complement wrap); no saturation logic is instantiated.

Verification
REQ-028 Load h={5,-5,15}, feed 1,0,0 -> data_out 5, -5, 15; each valid_out 4 cycles after its accept.
REQ-029 h={5,-5,15}, feed 2,3,4 -> outputs 10, 5, 35.
REQ-030 valid_in held high continuously -> ready_out=1 one cycle in every 5; only handshaked samples enter the delay line.
REQ-031 coef_wr h[1]=7 issued during MAC -> ignored, h[1] unchanged; coef_addr=3 with TAPS=3 -> no write.
REQ-032 h all -128, feed -128 three times -> third output 16383 with FIR_SAT_EN, -16384 without.
REQ-033 Assert rst on 2nd MAC cycle -> no valid_out, data_out=0, ready_out=1 next cycle; following sample 1 with h={5,-5,15} -> output 5.

Source files
------------

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential FIR filter with one shared signed multiplier; define FIR_SAT_EN to saturate data_out instead of wrapping.
module fir_mac_seq #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 3,
    parameter int DOUT_W = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  data_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic                      coef_wr,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic signed [DOUT_W-1:0]  data_out,
    output logic                      valid_out
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam int EXT_W  = ACC_W - PROD_W;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q [TAPS];
    logic signed [DATA_W-1:0]  x_d [TAPS];
    logic signed [COEF_W-1:0]  h_q [TAPS];
    logic signed [COEF_W-1:0]  h_d [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [DOUT_W-1:0]  dout_q, dout_d, dout_next;
    logic signed [PROD_W-1:0]  prod;
    logic                      addr_ok;

    assign prod      = x_q[idx_q] * h_q[idx_q];
    assign acc_sum   = acc_q + {{EXT_W{prod[PROD_W-1]}}, prod};
    assign addr_ok   = {1'b0, coef_addr} < (IDX_W+1)'(TAPS);
    assign ready_out = state_q == IDLE;
    assign valid_out = state_q == DONE;
    assign data_out  = dout_q;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DOUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    assign dout_next = acc_sum > SAT_MAX ? DOUT_W'(SAT_MAX) :
                       acc_sum < SAT_MIN ? DOUT_W'(SAT_MIN) : DOUT_W'(acc_sum);
`else
    assign dout_next = DOUT_W'(acc_sum);
`endif

    // Sequencer: accept shifts the delay line, MAC walks the taps, result is latched on entry to DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (coef_wr && addr_ok)
                    h_d[coef_addr] = coef_data;
                if (valid_in) begin
                    for (int k = TAPS - 1; k > 0; k--)
                        x_d[k] = x_q[k-1];
                    x_d[0]  = data_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(TAPS - 1)) begin
                    dout_d  = dout_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, delay line, coefficients and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '{default: '0};
            h_q     <= '{default: '0};
            acc_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed and randomized checks of fir_mac_seq against a sum-of-products reference model.
module tb_fir_mac_seq;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 3;
    localparam int DOUT_W = 15;
    localparam int AW     = $clog2(TAPS);

    logic                     clk = 0;
    logic                     rst = 1;
    logic signed [DATA_W-1:0] data_in = '0;
    logic                     valid_in = 0;
    logic                     ready_out;
    logic                     coef_wr = 0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic signed [DOUT_W-1:0] data_out;
    logic                     valid_out;

    int checks = 0;
    int errors = 0;
    int hs[TAPS];
    int xs[TAPS];

    always #5 clk = ~clk;

    fir_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .DOUT_W(DOUT_W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .data_out(data_out), .valid_out(valid_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int fold(input longint s);
        longint r;
        longint maxv;
        maxv = (64'sd1 <<< (DOUT_W - 1)) - 1;
`ifdef FIR_SAT_EN
        r = s > maxv ? maxv : (s < -maxv - 1 ? -maxv - 1 : s);
`else
        r = s & ((64'sd1 <<< DOUT_W) - 1);
        if (r > maxv) r = r - (64'sd1 <<< DOUT_W);
`endif
        return int'(r);
    endfunction

    function automatic int expect_out();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(xs[k]) * longint'(hs[k]);
        return fold(s);
    endfunction

    function automatic void model_accept(input int x);
        for (int k = TAPS - 1; k > 0; k--) xs[k] = xs[k-1];
        xs[0] = x;
    endfunction

    task automatic reset_dut;
        rst = 1;
        tick;
        tick;
        rst = 0;
        for (int k = 0; k < TAPS; k++) begin
            hs[k] = 0;
            xs[k] = 0;
        end
    endtask

    task automatic wr_coef(input int a, input int d);
        coef_wr   = 1;
        coef_addr = AW'(a);
        coef_data = COEF_W'(d);
        tick;
        coef_wr = 0;
        if (a < TAPS) hs[a] = d;
    endtask

    // mode 0: plain sample; 1: attempt h[1]=7 during MAC; 2: random coefficient write in the accept cycle
    task automatic send(input int x, input int mode);
        int n;
        int e;
        int wa;
        int wd;
        n = 0;
        while (!ready_out && n < 20) begin
            tick;
            n++;
        end
        chk("ready_wait", int'(ready_out), 1);
        data_in  = DATA_W'(x);
        valid_in = 1;
        if (mode == 2) begin
            wa        = int'($urandom_range(0, TAPS - 1));
            wd        = int'($urandom_range(0, 255)) - 128;
            coef_wr   = 1;
            coef_addr = AW'(wa);
            coef_data = COEF_W'(wd);
            hs[wa]    = wd;
        end
        tick;
        valid_in = 0;
        coef_wr  = 0;
        model_accept(x);
        e = expect_out();
        chk("busy", int'(ready_out), 0);
        n = 1;
        while (!valid_out && n < 20) begin
            if (mode == 1 && n == 1) begin
                coef_wr   = 1;
                coef_addr = AW'(1);
                coef_data = COEF_W'(7);
            end
            tick;
            coef_wr = 0;
            n++;
        end
        chk("latency", n, TAPS + 1);
        chk("data_out", int'(data_out), e);
        tick;
        chk("pulse", int'(valid_out), 0);
        chk("hold", int'(data_out), e);
    endtask

    initial begin
        int readies;
        int valids;
        int pend;
        bit was_ready;
        bit seen;

        reset_dut;
        chk("rst_ready", int'(ready_out), 1);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);

        wr_coef(0, 5);
        wr_coef(1, -5);
        wr_coef(2, 15);
        send(1, 0);
        chk("impulse0", int'(data_out), 5);
        send(0, 0);
        chk("impulse1", int'(data_out), -5);
        send(0, 0);
        chk("impulse2", int'(data_out), 15);
        send(2, 0);
        chk("seq0", int'(data_out), 10);
        send(3, 0);
        chk("seq1", int'(data_out), 5);
        send(4, 0);
        chk("seq2", int'(data_out), 35);

        readies  = 0;
        valids   = 0;
        pend     = 0;
        valid_in = 1;
        for (int i = 0; i < 15; i++) begin
            data_in = DATA_W'($urandom_range(0, 255));
            was_ready = ready_out;
            chk("ready_cadence", int'(ready_out), int'(i % 5 == 0));
            if (valid_out) begin
                valids++;
                chk("stream_data", int'(data_out), pend);
            end
            if (was_ready) readies++;
            tick;
            if (was_ready) begin
                model_accept(int'(data_in));
                pend = expect_out();
            end
        end
        valid_in = 0;
        chk("stream_readies", readies, 3);
        chk("stream_valids", valids, 3);

        send(0, 1);
        wr_coef(3, 99);
        send(0, 0);
        send(1, 0);
        send(0, 0);
        chk("h1_kept", int'(data_out), -5);
        send(0, 0);

        for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 255)) - 128, (i % 3 == 1) ? 2 : 0);

        reset_dut;
        for (int k = 0; k < TAPS; k++) wr_coef(k, -128);
        send(-128, 0);
        send(-128, 0);
        send(-128, 0);
`ifdef FIR_SAT_EN
        chk("extreme", int'(data_out), 16383);
`else
        chk("extreme", int'(data_out), -16384);
`endif

        reset_dut;
        wr_coef(0, 5);
        wr_coef(1, -5);
        wr_coef(2, 15);
        send(3, 0);
        data_in  = DATA_W'(9);
        valid_in = 1;
        tick;
        valid_in = 0;
        tick;
        rst = 1;
        tick;
        rst = 0;
        for (int k = 0; k < TAPS; k++) begin
            hs[k] = 0;
            xs[k] = 0;
        end
        chk("abort_valid", int'(valid_out), 0);
        chk("abort_data", int'(data_out), 0);
        chk("abort_ready", int'(ready_out), 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            seen |= valid_out;
            tick;
        end
        chk("abort_no_pulse", int'(seen), 0);
        wr_coef(0, 5);
        wr_coef(1, -5);
        wr_coef(2, 15);
        send(1, 0);
        chk("post_rst", int'(data_out), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
